// File: rtl/vertical_motion_ctrl.sv
// Vertical jump/gravity controller: a free-running frame timer triggers a three-phase
// update (velocity, position, landing) of height, velocity and motion state.
module vertical_motion_ctrl #(
  parameter int FRAME_DIV     = 833333,
  parameter int GROUND_HEIGHT = 50,
  parameter int CEILING       = 239,
  parameter int JUMP_VEL      = 20,
  parameter int GRAVITY       = 2,
  parameter int MAX_FALL      = 16,
  parameter int BUFFER_FRAMES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jump_key,
  input  logic              pause,
  output logic [7:0]        snoopy_y,
  output logic signed [7:0] velocity,
  output logic [1:0]        state,
  output logic              airborne,
  output logic              frame_done
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BW = (BUFFER_FRAMES > 0) ? $clog2(BUFFER_FRAMES + 1) : 1;

  localparam logic [CW-1:0]     CNT_LAST  = CW'(FRAME_DIV - 1);
  localparam logic [BW-1:0]     BUF_LOAD  = BW'(BUFFER_FRAMES);
  localparam logic signed [9:0] GRAV10    = 10'(GRAVITY);
  localparam logic signed [9:0] FLOOR_VEL = 10'(-MAX_FALL);
  localparam logic signed [9:0] GROUND10  = 10'(GROUND_HEIGHT);
  localparam logic signed [9:0] CEIL10    = 10'(CEILING);

  typedef enum logic [1:0] {GROUND = 2'b00, RISE = 2'b01, FALL = 2'b10} motion_t;
  typedef enum logic [1:0] {WAIT, PH_VEL, PH_POS, PH_LAND} phase_t;

  motion_t           mstate;
  phase_t            phase;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     jump_buf;
  logic              jump_prev;
  logic              consumed;
  logic              tick;
  logic              jump_edge;
  logic signed [9:0] vel10;
  logic signed [9:0] vel_sub;
  logic signed [9:0] y_sum;
  logic [7:0]        y_next;

  assign tick      = (cnt == CNT_LAST) && !pause;
  assign jump_edge = jump_key && !jump_prev;
  assign state     = mstate;
  assign airborne  = (mstate != GROUND);

  // Position math runs 10 bits wide so an overshoot clamps instead of wrapping.
  assign vel10   = {{2{velocity[7]}}, velocity};
  assign vel_sub = vel10 - GRAV10;
  assign y_sum   = $signed({2'b00, snoopy_y}) + vel10;

  always_comb begin
    y_next = y_sum[7:0];
    if (y_sum < GROUND10) begin
      y_next = 8'(GROUND_HEIGHT);
    end else if (y_sum > CEIL10) begin
      y_next = 8'(CEILING);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snoopy_y   <= 8'(GROUND_HEIGHT);
      velocity   <= '0;
      mstate     <= GROUND;
      phase      <= WAIT;
      cnt        <= '0;
      jump_buf   <= '0;
      jump_prev  <= 1'b0;
      consumed   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      jump_prev  <= jump_key;
      frame_done <= 1'b0;
      if (!pause) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end

      case (phase)
        WAIT: begin
          if (tick) begin
            phase    <= PH_VEL;
            consumed <= 1'b0;
          end
        end
        PH_VEL: begin
          phase <= PH_POS;
          case (mstate)
            GROUND: begin
              if (jump_buf != '0) begin
                velocity <= 8'(JUMP_VEL);
                mstate   <= RISE;
                jump_buf <= '0;
                consumed <= 1'b1;
              end else begin
                velocity <= '0;
              end
            end
            RISE: begin
              if (vel_sub <= 10'sd0) begin
                velocity <= '0;
                mstate   <= FALL;
              end else begin
                velocity <= vel_sub[7:0];
              end
            end
            default: begin
              velocity <= (vel_sub < FLOOR_VEL) ? FLOOR_VEL[7:0] : vel_sub[7:0];
            end
          endcase
        end
        PH_POS: begin
          snoopy_y   <= y_next;
          phase      <= PH_LAND;
          frame_done <= 1'b1;
        end
        default: begin
          phase <= WAIT;
          if (mstate == RISE && snoopy_y == 8'(CEILING)) begin
            velocity <= '0;
            mstate   <= FALL;
          end else if (mstate == FALL && snoopy_y == 8'(GROUND_HEIGHT)) begin
            velocity <= '0;
            mstate   <= GROUND;
          end
          if (jump_buf != '0 && !consumed) begin
            jump_buf <= jump_buf - 1'b1;
          end
        end
      endcase

      // A fresh key edge always reloads the buffer, overriding decrement or clear.
      if (jump_edge) begin
        jump_buf <= BUF_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_vertical_motion_ctrl.sv
// Directed bench for vertical_motion_ctrl with FRAME_DIV=8; a second instance
// with CEILING=120 shares the inputs for the ceiling-clamp scenario.
module tb_vertical_motion_ctrl;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              jump_key = 1'b0;
  logic              pause = 1'b0;
  logic [7:0]        snoopy_y, c_y;
  logic signed [7:0] velocity, c_vel;
  logic [1:0]        state, c_state;
  logic              airborne, c_air, frame_done, c_done;

  int checks = 0;
  int errors = 0;

  // Hand-derived trajectory for a single jump with default physics (frames 1..22).
  int exp_y [22] = '{70, 88, 104, 118, 130, 140, 148, 154, 158, 160, 160,
                     158, 154, 148, 140, 130, 118, 104, 88, 72, 56, 50};
  int exp_v [22] = '{20, 18, 16, 14, 12, 10, 8, 6, 4, 2, 0,
                     -2, -4, -6, -8, -10, -12, -14, -16, -16, -16, 0};

  always #5 clock = ~clock;

  vertical_motion_ctrl #(.FRAME_DIV(8)) dut (
    .clock(clock), .reset(reset), .jump_key(jump_key), .pause(pause),
    .snoopy_y(snoopy_y), .velocity(velocity), .state(state),
    .airborne(airborne), .frame_done(frame_done)
  );

  vertical_motion_ctrl #(.FRAME_DIV(8), .CEILING(120)) ceil_dut (
    .clock(clock), .reset(reset), .jump_key(jump_key), .pause(pause),
    .snoopy_y(c_y), .velocity(c_vel), .state(c_state),
    .airborne(c_air), .frame_done(c_done)
  );

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1; jump_key = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Waits for frame_done, then one more cycle so the landing-phase updates are visible.
  task automatic next_frame(output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 40) begin
      @(negedge clock);
      cycles++;
      got = frame_done;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", cycles);
    end
    @(negedge clock);
  endtask

  task automatic pulse_key;
    jump_key = 1'b1;
    @(negedge clock);
    jump_key = 1'b0;
  endtask

  task automatic test_reset;
    int cyc;
    @(negedge clock);
    reset = 1'b1; jump_key = 1'b1; pause = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({snoopy_y, velocity, state, airborne, frame_done} !== {8'd50, 8'd0, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: y=%0d v=%0d st=%0d air=%0d fd=%0d required 50 0 0 0 0",
               snoopy_y, velocity, state, airborne, frame_done);
    end
    jump_key = 1'b0; pause = 1'b0; reset = 1'b0;
    next_frame(cyc);
    checks++;
    if (cyc != 10) begin
      errors++; $display("FAIL reset_first_frame: %0d cycles, required 10", cyc);
    end
    checks++;
    if (state !== 2'b00 || velocity !== 8'sd0 || snoopy_y !== 8'd50) begin
      errors++;
      $display("FAIL reset_no_launch: st=%0d v=%0d y=%0d required 0 0 50", state, velocity, snoopy_y);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_done_width: %0b one cycle after pulse, required 0", frame_done);
    end
    next_frame(cyc);
    checks++;
    if (cyc != 7) begin
      errors++; $display("FAIL idle_frame_period: %0d, required 7", cyc);
    end
  endtask

  task automatic test_single_jump;
    int cyc;
    do_reset();
    next_frame(cyc);
    pulse_key();
    for (int i = 0; i < 22; i++) begin
      int es;
      es = (i < 10) ? 1 : (i < 21) ? 2 : 0;
      next_frame(cyc);
      checks++;
      if (cyc != ((i == 0) ? 6 : 7)) begin
        errors++; $display("FAIL jump_period frame %0d: %0d cycles", i + 1, cyc);
      end
      checks++;
      if (snoopy_y !== 8'(exp_y[i])) begin
        errors++; $display("FAIL jump_y frame %0d: got %0d required %0d", i + 1, snoopy_y, exp_y[i]);
      end
      checks++;
      if (velocity !== 8'(exp_v[i])) begin
        errors++; $display("FAIL jump_v frame %0d: got %0d required %0d", i + 1, velocity, exp_v[i]);
      end
      checks++;
      if (state !== 2'(es) || airborne !== (es != 0)) begin
        errors++;
        $display("FAIL jump_state frame %0d: st=%0d air=%0b required st=%0d", i + 1, state, airborne, es);
      end
    end
  endtask

  task automatic test_held_key;
    int cyc;
    do_reset();
    next_frame(cyc);
    jump_key = 1'b1;
    for (int f = 1; f <= 25; f++) begin
      next_frame(cyc);
      if (f == 1) begin
        checks++;
        if (velocity !== 8'sd20 || state !== 2'b01) begin
          errors++; $display("FAIL held_launch: v=%0d st=%0d required 20 1", velocity, state);
        end
      end
      if (f >= 22) begin
        checks++;
        if (state !== 2'b00 || snoopy_y !== 8'd50 || velocity !== 8'sd0) begin
          errors++;
          $display("FAIL held_relaunch frame %0d: st=%0d y=%0d v=%0d required 0 50 0", f, state, snoopy_y, velocity);
        end
      end
    end
    jump_key = 1'b0;
  endtask

  task automatic test_buffer_window;
    int cyc;
    int lead;
    for (int k = 0; k < 2; k++) begin
      lead = (k == 0) ? 2 : 5;
      do_reset();
      next_frame(cyc);
      pulse_key();
      for (int f = 1; f <= 22; f++) begin
        next_frame(cyc);
        checks++;
        if (snoopy_y !== 8'(exp_y[f-1]) || velocity !== 8'(exp_v[f-1])) begin
          errors++;
          $display("FAIL buf_lead%0d frame %0d: y=%0d v=%0d required %0d %0d",
                   lead, f, snoopy_y, velocity, exp_y[f-1], exp_v[f-1]);
        end
        if (f == 21 - lead) pulse_key();
      end
      next_frame(cyc);
      checks++;
      if (lead == 2 && (snoopy_y !== 8'd70 || velocity !== 8'sd20 || state !== 2'b01)) begin
        errors++;
        $display("FAIL buf_launch: y=%0d v=%0d st=%0d required 70 20 1", snoopy_y, velocity, state);
      end else if (lead == 5 && (snoopy_y !== 8'd50 || velocity !== 8'sd0 || state !== 2'b00)) begin
        errors++;
        $display("FAIL buf_expired: y=%0d v=%0d st=%0d required 50 0 0", snoopy_y, velocity, state);
      end
    end
  endtask

  task automatic test_ceiling;
    int cyc;
    do_reset();
    next_frame(cyc);
    pulse_key();
    for (int f = 1; f <= 6; f++) begin
      next_frame(cyc);
      checks++;
      if (c_y > 8'd120) begin
        errors++; $display("FAIL ceil_bound frame %0d: y=%0d above 120", f, c_y);
      end
      if (f == 4) begin
        checks++;
        if (c_y !== 8'd118 || c_vel !== 8'sd14 || c_state !== 2'b01) begin
          errors++; $display("FAIL ceil_pre: y=%0d v=%0d st=%0d required 118 14 1", c_y, c_vel, c_state);
        end
      end
      if (f == 5) begin
        checks++;
        if (c_y !== 8'd120 || c_vel !== 8'sd0 || c_state !== 2'b10 || c_air !== 1'b1) begin
          errors++;
          $display("FAIL ceil_hit: y=%0d v=%0d st=%0d air=%0b required 120 0 2 1", c_y, c_vel, c_state, c_air);
        end
      end
      if (f == 6) begin
        checks++;
        if (c_y !== 8'd118 || c_vel !== -8'sd2 || c_done !== 1'b0) begin
          errors++; $display("FAIL ceil_fall: y=%0d v=%0d fd=%0b required 118 -2 0", c_y, c_vel, c_done);
        end
      end
    end
  endtask

  task automatic test_pause;
    int cyc;
    int done_seen;
    int moved;
    do_reset();
    next_frame(cyc);
    pulse_key();
    repeat (3) next_frame(cyc);
    done_seen = 0;
    moved = 0;
    pause = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (frame_done) done_seen++;
      if (snoopy_y !== 8'd104 || velocity !== 8'sd16 || state !== 2'b01) moved++;
    end
    pause = 1'b0;
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL pause_ticks: %0d frame_done pulses, required 0", done_seen);
    end
    checks++;
    if (moved != 0) begin
      errors++; $display("FAIL pause_frozen: outputs moved in %0d cycles, required 0", moved);
    end
    next_frame(cyc);
    checks++;
    if (cyc != 7) begin
      errors++; $display("FAIL pause_resume: %0d cycles to next frame, required 7", cyc);
    end
    checks++;
    if (snoopy_y !== 8'd118 || velocity !== 8'sd14) begin
      errors++; $display("FAIL pause_next: y=%0d v=%0d required 118 14", snoopy_y, velocity);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    do_reset();
    next_frame(cyc);
    pulse_key();
    repeat (3) next_frame(cyc);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({snoopy_y, velocity, state, frame_done} !== {8'd50, 8'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_at_pos: y=%0d v=%0d st=%0d fd=%0d required 50 0 0 0",
               snoopy_y, velocity, state, frame_done);
    end
    reset = 1'b0;
    next_frame(cyc);
    checks++;
    if (cyc != 10) begin
      errors++; $display("FAIL reset_abandon: frame_done after %0d cycles, required 10", cyc);
    end
    checks++;
    if (snoopy_y !== 8'd50 || state !== 2'b00) begin
      errors++; $display("FAIL reset_after: y=%0d st=%0d required 50 0", snoopy_y, state);
    end
  endtask

  initial begin
    test_reset();
    test_single_jump();
    test_held_key();
    test_buffer_window();
    test_ceiling();
    test_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
